mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
MEM-stage request unit that sits directly upstream of the data-cache/uncache wrapper.
- Accepts one memory instruction at a time from EX and registers it.
- Generates the wrapper's CPU-side command set: address, byte enables, read/write, aligned write data, uncache select, illegal flag and new-request pulse.
- Holds the command while the cache stalls.
- Returns the extended load result, or an address-error exception, to WB.

Parameters:
K0_UNCACHED, 0, 1 = kseg0 (addr[31:29]=3'b100) accesses are also routed uncached.
MAP_KSEG01, 1, 1 = kseg0/kseg1 addresses are mapped to physical {3'b000,addr[28:0]}; 0 = address passes through unchanged.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
ex_valid  in  1  EX presents a memory instruction
ex_mem_op  in  4  0000 LB, 0001 LBU, 0010 LH, 0011 LHU, 0100 LW, 1000 SB, 1001 SH, 1010 SW
ex_addr  in  32  virtual effective address
ex_wdata  in  32  store source register
mem_allowin  out  1  request accepted when ex_valid && mem_allowin
cpu_addr  out  32  access address to cache wrapper
cpu_byteenable  out  4  byte lanes
cpu_read  out  1  read command
cpu_write  out  1  write command
cpu_wrdata  out  32  lane-replicated store data
cpu_kseg0_uncache  out  1  route the access to the uncache path
cpu_addr_illegal  out  1  cancels the cache command
new_lw_ins_tocache  out  1  first cycle of a new access
cpu_rddata  in  32  cache read data
cpu_stall  in  1  cache busy; command must be held
wb_valid  out  1  result or exception available
wb_ready  in  1  WB consumes the result
wb_data  out  32  extended load data (0 for stores)
wb_exc  out  1  address error
wb_exc_store  out  1  1 = AdES, 0 = AdEL
wb_badvaddr  out  32  faulting virtual address

Behaviour:
Reset:
- State IDLE.
- All outputs 0 except mem_allowin=1.
- Reset mid-ACCESS drops the command immediately; the cache shares rst.

FSM states: IDLE, ACCESS, DONE.
- mem_allowin = (IDLE) || (DONE && wb_ready).
- On accept: latch op, addr and wdata.

Accept path:
- Misaligned access (halfword with addr[0]!=0, or word with addr[1:0]!=0) goes to DONE with wb_exc=1, wb_exc_store=op[3], wb_badvaddr=addr. No cache command is issued.
- Any unlisted op code goes to DONE with wb_data=0 and no exception.
- Otherwise go to ACCESS.

ACCESS:
- cpu_read = !op[3]; cpu_write = op[3].
- All cpu_* outputs come only from the latched registers and are stable for the whole state.
- new_lw_ins_tocache = 1 in the first ACCESS cycle only.
- On the first cycle with cpu_stall=0: capture the extended cpu_rddata, then go to DONE.
- Minimum latency from accept to wb_valid is 2 cycles.

DONE:
- wb_valid=1 and all cpu_* commands are 0.
- wb_ready && ex_valid: accept the next request, back-to-back, into ACCESS or DONE.
- wb_ready && !ex_valid: go to IDLE.

Outside ACCESS, cpu_read, cpu_write, cpu_byteenable and new_lw_ins_tocache are 0.

Byte enables:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011<<addr[1:0]
- word: 4'b1111

Write data:
- byte: {4{wdata[7:0]}}
- half: {2{wdata[15:0]}}
- word: wdata unchanged

Load extension: lane = rddata >> (8*addr[1:0]).
- LB/LH sign-extend bit 7/15 of the lane.
- LBU/LHU zero-extend.
- LW passes rddata unchanged.

Uncache and mapping:
- cpu_kseg0_uncache = (addr[31:29]==3'b101) || (K0_UNCACHED && addr[31:29]==3'b100).
- cpu_addr is mapped per MAP_KSEG01; other segments pass through.
- cpu_addr_illegal is always 0 in ACCESS, because misaligned accesses never reach ACCESS.

Simultaneous events:
- Stall deasserting in the same cycle as wb_ready has no effect on the ACCESS→DONE transition; the result always passes through DONE unless MEM_RESULT_BYPASS_EN is defined.

Optional Feature:
MEM_RESULT_BYPASS_EN
- Defined: in ACCESS with cpu_stall=0 && wb_ready=1:
  - wb_valid=1 and wb_data = the combinational extended result in that same cycle.
  - The FSM skips DONE and goes to IDLE, or straight to ACCESS if ex_valid && mem_allowin.
  - mem_allowin additionally includes that condition.
  - Minimum latency becomes 1 cycle.
- Undefined: results are always registered through DONE, as described above.

Test Plan:
- Reset mid-ACCESS, with cpu_read=1 and stall high → outputs 0 asynchronously; after release, state IDLE and mem_allowin=1.
- LB at addr 0x80001003, cpu_rddata=0x80AA5511, cpu_stall low → cpu_byteenable=4'b1000, cpu_addr=0x00001003, cpu_kseg0_uncache=0, wb_data=0xFFFFFF80, new_lw_ins_tocache high for exactly 1 cycle.
- SH at 0xA0000002, data 0x1234ABCD, cpu_stall high for 5 cycles → cpu_byteenable=4'b1100, cpu_wrdata=0xABCDABCD, cpu_kseg0_uncache=1, command held stable for 6 cycles, then wb_valid with wb_data=0.
- LW at 0x80000006 → no cpu_read pulse, wb_exc=1, wb_exc_store=0, wb_badvaddr=0x80000006; the same test with SW gives wb_exc_store=1.
- Back-to-back LHU 0x80000000 then LW 0x80000004 with wb_ready tied high → second accept occurs in the DONE cycle of the first; LHU of rddata 0x0000F00D gives wb_data=0x0000F00D.
- With MEM_RESULT_BYPASS_EN defined, LW with stall low and wb_ready high → wb_valid 1 cycle after accept; without the macro → 2 cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage request unit feeding the data-cache/uncache wrapper.
// Optional feature: define MEM_RESULT_BYPASS_EN to return results in the ACCESS cycle.
module mem_access_unit #(
  parameter bit K0_UNCACHED = 1'b0,
  parameter bit MAP_KSEG01  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        mem_allowin,
  output logic [31:0] cpu_addr,
  output logic [3:0]  cpu_byteenable,
  output logic        cpu_read,
  output logic        cpu_write,
  output logic [31:0] cpu_wrdata,
  output logic        cpu_kseg0_uncache,
  output logic        cpu_addr_illegal,
  output logic        new_lw_ins_tocache,
  input  logic [31:0] cpu_rddata,
  input  logic        cpu_stall,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic        wb_exc,
  output logic        wb_exc_store,
  output logic [31:0] wb_badvaddr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        first_q, first_d;

  size_t       size_cur;
  size_t       size_new;
  logic        misaligned;
  logic [31:0] lane;
  logic [31:0] ext;
  logic        bypass_fire;
  logic        accept;
  logic        in_acc;
  logic        in_done;

  function automatic size_t op_size(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b1000: op_size = SZ_BYTE;
      4'b0010, 4'b0011, 4'b1001: op_size = SZ_HALF;
      4'b0100, 4'b1010:          op_size = SZ_WORD;
      default:                   op_size = SZ_NONE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    in_acc   = (state_q == ACCESS);
    in_done  = (state_q == DONE);
    size_cur = op_size(op_q);
    size_new = op_size(ex_mem_op);
    lane     = cpu_rddata >> {addr_q[1:0], 3'b000};
    case (op_q)
      4'b0000: ext = {{24{lane[7]}}, lane[7:0]};
      4'b0001: ext = {24'h0, lane[7:0]};
      4'b0010: ext = {{16{lane[15]}}, lane[15:0]};
      4'b0011: ext = {16'h0, lane[15:0]};
      4'b0100: ext = cpu_rddata;
      default: ext = '0;
    endcase
`ifdef MEM_RESULT_BYPASS_EN
    bypass_fire = in_acc && !cpu_stall && wb_ready;
`else
    bypass_fire = 1'b0;
`endif
    mem_allowin = (state_q == IDLE) || (in_done && wb_ready) || bypass_fire;
    accept      = ex_valid && mem_allowin;
    misaligned  = ((size_new == SZ_HALF) && ex_addr[0]) ||
                  ((size_new == SZ_WORD) && (ex_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    exc_d   = exc_q;
    first_d = 1'b0;
    case (state_q)
      ACCESS: begin
        if (!cpu_stall) begin
          res_d   = ext;
          exc_d   = 1'b0;
          state_d = bypass_fire ? IDLE : DONE;
        end
      end
      DONE: begin
        if (wb_ready) state_d = IDLE;
      end
      default: ;
    endcase
    // A new accept overrides the hand-off targets chosen above.
    if (accept) begin
      op_d    = ex_mem_op;
      addr_d  = ex_addr;
      wdata_d = ex_wdata;
      res_d   = '0;
      if (size_new == SZ_NONE) begin
        exc_d   = 1'b0;
        state_d = DONE;
      end else if (misaligned) begin
        exc_d   = 1'b1;
        state_d = DONE;
      end else begin
        exc_d   = 1'b0;
        first_d = 1'b1;
        state_d = ACCESS;
      end
    end
  end

  always_comb begin
    cpu_read           = in_acc && !op_q[3];
    cpu_write          = in_acc && op_q[3];
    cpu_addr_illegal   = 1'b0;
    new_lw_ins_tocache = in_acc && first_q;
    cpu_byteenable     = '0;
    cpu_wrdata         = '0;
    cpu_addr           = '0;
    cpu_kseg0_uncache  = 1'b0;
    if (in_acc) begin
      case (size_cur)
        SZ_BYTE: begin
          cpu_byteenable = 4'b0001 << addr_q[1:0];
          cpu_wrdata     = {4{wdata_q[7:0]}};
        end
        SZ_HALF: begin
          cpu_byteenable = 4'b0011 << addr_q[1:0];
          cpu_wrdata     = {2{wdata_q[15:0]}};
        end
        SZ_WORD: begin
          cpu_byteenable = 4'b1111;
          cpu_wrdata     = wdata_q;
        end
        default: ;
      endcase
      if (MAP_KSEG01 && (addr_q[31:30] == 2'b10)) cpu_addr = {3'b000, addr_q[28:0]};
      else                                         cpu_addr = addr_q;
      cpu_kseg0_uncache = (addr_q[31:29] == 3'b101) ||
                          (K0_UNCACHED && (addr_q[31:29] == 3'b100));
    end
    wb_valid     = in_done || bypass_fire;
    wb_exc       = in_done && exc_q;
    wb_exc_store = in_done && exc_q && op_q[3];
    wb_badvaddr  = (in_done && exc_q) ? addr_q : '0;
    if (in_done)          wb_data = res_q;
    else if (bypass_fire) wb_data = ext;
    else                  wb_data = '0;
  end

endmodule
